// File: rtl/cache_controller.sv
// Direct-mapped write-through, no-write-allocate cache controller.
// Optional hit/miss statistics counters enabled by defining CACHE_STATS_EN.
module cache_controller #(
    parameter int ADDR_W      = 15,
    parameter int WORD_W      = 32,
    parameter int LINES       = 1024,
    parameter int MEM_LATENCY = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_W-1:0]   cpu_address,
    input  logic [WORD_W-1:0]   cpu_write_data,
    input  logic                cpu_read,
    input  logic                cpu_write,
    output logic [WORD_W-1:0]   cpu_read_data,
    output logic                cpu_ready,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [WORD_W-1:0]   mem_write_data,
    output logic                mem_read,
    output logic                mem_write,
`ifdef CACHE_STATS_EN
    output logic [31:0]         hit_count,
    output logic [31:0]         miss_count,
`endif
    input  logic [4*WORD_W-1:0] mem_block_data
);
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, MISS, WRITE} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] wdata_q, wdata_d;
    logic [LINES-1:0]  valid_q, valid_d;

    logic [TAG_W-1:0]  tag_mem  [LINES];
    logic [WORD_W-1:0] data_mem [LINES][4];

    logic [1:0]        cpu_off;
    logic [IDX_W-1:0]  cpu_idx;
    logic [TAG_W-1:0]  cpu_tag;
    logic [IDX_W-1:0]  acc_idx;
    logic [TAG_W-1:0]  acc_tag;
    logic              hit;
    logic              rd_hit;
    logic              fill_en;
    logic              wr_hit_en;

    assign cpu_off = cpu_address[1:0];
    assign cpu_idx = cpu_address[IDX_W+1:2];
    assign cpu_tag = cpu_address[ADDR_W-1:IDX_W+2];
    assign acc_idx = addr_q[IDX_W+1:2];
    assign acc_tag = addr_q[ADDR_W-1:IDX_W+2];

    assign hit = (cpu_read || cpu_write) && valid_q[cpu_idx]
                 && (tag_mem[cpu_idx] == cpu_tag);
    // A store takes priority, so a read hit only counts when no store is pending.
    assign rd_hit = (state_q == IDLE) && cpu_read && !cpu_write && hit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        valid_d   = valid_q;
        fill_en   = 1'b0;
        wr_hit_en = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_write) begin
                    state_d   = WRITE;
                    cnt_d     = CNT_LOAD;
                    addr_d    = cpu_address;
                    wdata_d   = cpu_write_data;
                    wr_hit_en = hit;
                end else if (cpu_read && !hit) begin
                    state_d = MISS;
                    cnt_d   = CNT_LOAD;
                    addr_d  = cpu_address;
                end
            end
            MISS: begin
                if (cnt_q == '0) begin
                    state_d          = IDLE;
                    fill_en          = 1'b1;
                    valid_d[acc_idx] = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            WRITE: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cpu_ready      = 1'b0;
        cpu_read_data  = '0;
        mem_address    = '0;
        mem_write_data = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        case (state_q)
            IDLE: begin
                cpu_ready = rd_hit;
                if (rd_hit) cpu_read_data = data_mem[cpu_idx][cpu_off];
            end
            MISS: begin
                mem_read    = 1'b1;
                mem_address = {addr_q[ADDR_W-1:2], 2'b00};
            end
            WRITE: begin
                mem_write      = 1'b1;
                mem_address    = addr_q;
                mem_write_data = wdata_q;
                cpu_ready      = (cnt_q == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            valid_q <= valid_d;
        end
    end

    // Tag/data storage is not reset; valid bits alone qualify its contents.
    always_ff @(posedge clk) begin
        if (fill_en && !rst) begin
            tag_mem[acc_idx] <= acc_tag;
            for (int k = 0; k < 4; k++)
                data_mem[acc_idx][k] <= mem_block_data[k*WORD_W +: WORD_W];
        end
        if (wr_hit_en && !rst)
            data_mem[cpu_idx][cpu_off] <= cpu_write_data;
    end

`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d;
    logic [31:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        if (rd_hit && hit_cnt_q != 32'hFFFF_FFFF)
            hit_cnt_d = hit_cnt_q + 32'd1;
        if (state_q == IDLE && state_d == MISS && miss_cnt_q != 32'hFFFF_FFFF)
            miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed self-checking bench for cache_controller.
// Memory model: word at address a initially holds a; stores write through.
module tb_cache_controller;
    logic         clk = 1'b0;
    logic         rst;
    logic [14:0]  cpu_address;
    logic [31:0]  cpu_write_data;
    logic         cpu_read;
    logic         cpu_write;
    logic [31:0]  cpu_read_data;
    logic         cpu_ready;
    logic [14:0]  mem_address;
    logic [31:0]  mem_write_data;
    logic         mem_read;
    logic         mem_write;
    logic [127:0] mem_block_data;
`ifdef CACHE_STATS_EN
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;
`endif

    logic [31:0] mem [32768];
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    cache_controller dut (
        .clk            (clk),
        .rst            (rst),
        .cpu_address    (cpu_address),
        .cpu_write_data (cpu_write_data),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_read_data  (cpu_read_data),
        .cpu_ready      (cpu_ready),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
`ifdef CACHE_STATS_EN
        .hit_count      (hit_count),
        .miss_count     (miss_count),
`endif
        .mem_block_data (mem_block_data)
    );

    always_comb begin
        for (int k = 0; k < 4; k++)
            mem_block_data[k*32 +: 32] = mem[{mem_address[14:2], 2'(k)}];
    end

    always @(posedge clk)
        if (mem_write) mem[mem_address] <= mem_write_data;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_read(input string tag, input logic [14:0] a,
                           input logic [31:0] exp_d, input int exp_lat);
        int lat = 0;
        int nrd = 0;
        int bad = 0;
        @(posedge clk);
        #1 cpu_address = a;
        cpu_read = 1'b1;
        forever begin
            @(negedge clk);
            if (cpu_ready || lat >= 20) break;
            if (mem_read) begin
                nrd++;
                if (mem_address !== {a[14:2], 2'b00}) bad++;
            end
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        check({tag, "_data"}, 64'(cpu_read_data), 64'(exp_d));
        check({tag, "_nrd"}, 64'(nrd), 64'(exp_lat == 0 ? 0 : 4));
        check({tag, "_maddr"}, 64'(bad), 64'd0);
        @(posedge clk);
        #1 cpu_read = 1'b0;
    endtask

    task automatic do_write(input string tag, input logic [14:0] a,
                            input logic [31:0] d);
        int lat = 0;
        int nwr = 0;
        int bad = 0;
        @(posedge clk);
        #1 cpu_address = a;
        cpu_write_data = d;
        cpu_write = 1'b1;
        forever begin
            @(negedge clk);
            if (mem_write) begin
                nwr++;
                if (mem_address !== a || mem_write_data !== d) bad++;
            end
            if (cpu_ready || lat >= 20) break;
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd4);
        check({tag, "_nwr"}, 64'(nwr), 64'd4);
        check({tag, "_mbus"}, 64'(bad), 64'd0);
        @(posedge clk);
        #1 cpu_write = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 32'(i);
        rst = 1'b1;
        cpu_address = 15'h0400;
        cpu_write_data = '0;
        cpu_read = 1'b1;
        cpu_write = 1'b0;
        #12;
        check("rst_ready", 64'(cpu_ready), 64'd0);
        check("rst_mrd", 64'(mem_read), 64'd0);
        check("rst_mwr", 64'(mem_write), 64'd0);
        check("rst_bus", 64'(mem_address) | 64'(mem_write_data)
              | 64'(cpu_read_data), 64'd0);
        cpu_read = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        do_read("t1", 15'h0400, 32'd1024, 5);
        do_read("t2", 15'h0401, 32'd1025, 0);
`ifdef CACHE_STATS_EN
        check("t2_hits", 64'(hit_count), 64'd2);
        check("t2_miss", 64'(miss_count), 64'd1);
`endif
        do_write("t3w", 15'h0401, 32'hDEAD_BEEF);
        do_read("t3r", 15'h0401, 32'hDEAD_BEEF, 0);
        do_write("t4w", 15'h2000, 32'd7);
        do_read("t4r", 15'h2000, 32'd7, 5);
        do_read("t5a", 15'h0400, 32'd1024, 0);
        do_read("t5b", 15'h1400, 32'h1400, 5);
        do_read("t5c", 15'h0400, 32'd1024, 5);
`ifdef CACHE_STATS_EN
        check("t5_miss", 64'(miss_count), 64'd4);
`endif

        @(posedge clk);
        #1 cpu_address = 15'h0800;
        cpu_read = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("t6_inmiss", 64'(mem_read), 64'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("t6_mrd", 64'(mem_read), 64'd0);
        check("t6_ready", 64'(cpu_ready), 64'd0);
        check("t6_bus", 64'(mem_address) | 64'(cpu_read_data), 64'd0);
        cpu_read = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        do_read("t6r", 15'h0800, 32'h0800, 5);
        do_read("t6v", 15'h0401, 32'hDEAD_BEEF, 5);
`ifdef CACHE_STATS_EN
        check("t6_hits", 64'(hit_count), 64'd2);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cache_controller.md
Name: cache_controller

Overview:
- Direct-mapped, write-through, no-write-allocate cache controller with its own tag/valid/data arrays.
- Sits between the CPU load/store port and the word-addressed data memory, which returns a 4-word block combinationally.
- Sequences memory reads for misses (modelled latency via a counter) and forwards every store to memory.
- Stalls the CPU through a cpu_ready handshake.

Parameters:
ADDR_W, 15, word address width
WORD_W, 32, data word width
LINES, 1024, number of cache lines; index width IDX_W = log2(LINES)
MEM_LATENCY, 4, cycles each memory access occupies (>=1)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous active-high reset
cpu_address  in  ADDR_W  word address; held stable until cpu_ready
cpu_write_data  in  WORD_W  store data
cpu_read  in  1  load request
cpu_write  in  1  store request
cpu_read_data  out  WORD_W  load data, valid when cpu_ready && cpu_read
cpu_ready  out  1  request complete this cycle
mem_address  out  ADDR_W  memory address
mem_write_data  out  WORD_W  memory store data
mem_read  out  1  memory block read strobe
mem_write  out  1  memory word write strobe
mem_block_data  in  4*WORD_W  block from memory; word k at bits [k*WORD_W +: WORD_W]

Behaviour:
- Address split: offset = addr[1:0], index = addr[IDX_W+1:2], tag = addr[ADDR_W-1:IDX_W+2]. Defaults give a 3-bit tag.
- Per line: valid bit, tag, 4 data words. hit = cpu request && valid[index] && tag match.
- Reset (asynchronous):
  - state=IDLE, counter=0, all valid bits=0.
  - cpu_ready=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0, cpu_read_data=0.
  - Data/tag arrays are not cleared.
  - Reset mid-miss or mid-write aborts the access; no line is filled.
- States:
  - IDLE:
    - cpu_write (priority over cpu_read if both are set) -> WRITE, counter=MEM_LATENCY-1. If the write hits, the cached word is updated at this edge.
    - cpu_read hit -> cpu_ready=1 combinationally in the same cycle, cpu_read_data=cached word, stay IDLE (0-cycle stall).
    - cpu_read miss -> MISS, counter=MEM_LATENCY-1.
  - MISS:
    - mem_read=1, mem_address={addr[ADDR_W-1:2],2'b00}; counter decrements each cycle.
    - At counter==0: latch mem_block_data into the line, set tag, valid=1, -> IDLE.
    - The following IDLE cycle hits, so total read-miss latency = MEM_LATENCY+1 cycles from request to cpu_ready.
  - WRITE:
    - mem_write=1, mem_address=cpu_address, mem_write_data=cpu_write_data for MEM_LATENCY cycles.
    - cpu_ready=1 in the last cycle (counter==0), -> IDLE.
    - A write miss leaves the cache unchanged.
- Outside MISS/WRITE: mem_read=mem_write=0 and cpu_ready=0 unless there is an IDLE read hit.
- Request dropped mid-access: the access still completes (fill or memory write), then returns to IDLE.
- Back-to-back requests: a new request is sampled only in IDLE. After a WRITE completes, the next request's decision is made the following cycle.
- Counter wraps never: it is loaded only on the IDLE transition and stops at 0.

Optional Feature:
CACHE_STATS_EN
- Defined: adds outputs hit_count[31:0] and miss_count[31:0], reset to 0.
  - hit_count +1 on each IDLE read-hit cycle with cpu_ready.
  - miss_count +1 on each IDLE->MISS transition.
  - Both saturate at 32'hFFFF_FFFF.
  - Writes are not counted.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, read addr 0x0400 (memory word=1024) -> mem_read high 4 cycles at mem_address 0x0400, cpu_ready in cycle 5, cpu_read_data=1024.
2. Read 0x0401 right after test 1 -> hit: cpu_ready same cycle, data=1025, no mem_read; with CACHE_STATS_EN, hit_count=2, miss_count=1.
3. Write 0x0401 data 0xDEAD_BEEF (hit) -> mem_write high 4 cycles, cpu_ready in 4th; subsequent read 0x0401 hits and returns 0xDEAD_BEEF.
4. Write miss 0x2000 data 7 -> mem_write 4 cycles; read 0x2000 then misses (valid unchanged) and returns 7 after 5 cycles.
5. Conflict: read 0x0400, then read 0x1400 (same index, different tag) -> second misses and refills; reading 0x0400 again misses.
6. Assert rst during cycle 2 of a MISS -> all outputs 0 immediately; the same read afterwards takes the full 5-cycle miss path.
